chess_puzzle_sequencer: RTL

//  Session controller in front of the chess puzzle checker. Debounces the raw
//  KEY, drives the checker's active-low verify strobe, and times each puzzle

---
 rtl/chess_puzzle_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/chess_puzzle_sequencer.sv
// Session controller for the chess puzzle checker: debounced submit key,
// active-low verify strobes, per-puzzle seconds countdown and scoring.
module chess_puzzle_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 4,
  parameter int FEEDBACK_CYCLES = 100000000,
  parameter int TICK_CYCLES     = 50000000,
  parameter int TIME_LIMIT_S    = 60,
  parameter int NUM_PUZZLES     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic       start,
  input  logic       correct,
  output logic       verify,
  output logic [2:0] puzzle_num,
  output logic [2:0] score,
  output logic [6:0] secs_left,
  output logic       last_ok,
  output logic       busy,
  output logic       game_over
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PMAX = (FEEDBACK_CYCLES > PULSE_CYCLES) ? FEEDBACK_CYCLES : PULSE_CYCLES;
  localparam int PW   = $clog2(PMAX + 2);
  localparam int TW   = $clog2(TICK_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, ANSWER, SUBMIT, SAMPLE, FEEDBACK, ADVANCE, DONE
  } state_t;

  state_t          state, state_n;
  logic            key_s1, key_s2, key_lvl, press;
  logic [DW-1:0]   db_cnt;
  logic [PW-1:0]   phase_cnt;
  logic [TW-1:0]   tick_cnt;
  logic            timed_out;
  logic            sample_ok;
  logic            start_ok;

  // Debouncer: the accepted level only moves after DEBOUNCE_CYCLES
  // consecutive synchronised samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1  <= 1'b1;
      key_s2  <= 1'b1;
      key_lvl <= 1'b1;
      db_cnt  <= '0;
      press   <= 1'b0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      press  <= 1'b0;
      if (key_s2 == key_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        key_lvl <= key_s2;
        db_cnt  <= '0;
        press   <= ~key_s2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start_ok  = 1'b0;
    sample_ok = correct & ~timed_out;
    case (state)
      IDLE, DONE: begin
        start_ok = start;
        if (start) state_n = ANSWER;
      end
      ANSWER:   if (press || secs_left == 7'd0)              state_n = SUBMIT;
      SUBMIT:   if (phase_cnt == PW'(PULSE_CYCLES - 1))     state_n = SAMPLE;
      SAMPLE:   if (phase_cnt == PW'(1))                    state_n = FEEDBACK;
      FEEDBACK: if (phase_cnt == PW'(FEEDBACK_CYCLES - 1))  state_n = ADVANCE;
      ADVANCE:  if (phase_cnt == PW'(PULSE_CYCLES - 1))
                  state_n = (puzzle_num == 3'(NUM_PUZZLES - 1)) ? DONE : ANSWER;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      verify     <= 1'b1;
      phase_cnt  <= '0;
      tick_cnt   <= '0;
      secs_left  <= 7'(TIME_LIMIT_S);
      puzzle_num <= '0;
      score      <= '0;
      last_ok    <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      // verify is registered from the next state so the checker sees a clean strobe
      verify <= !(state_n == SUBMIT || state_n == ADVANCE);

      if (state_n != state || state == IDLE || state == ANSWER || state == DONE)
        phase_cnt <= '0;
      else
        phase_cnt <= phase_cnt + 1'b1;

      if (start_ok) begin
        score      <= '0;
        puzzle_num <= '0;
        secs_left  <= 7'(TIME_LIMIT_S);
      end

      if (state != ANSWER && state_n == ANSWER) begin
        tick_cnt <= '0;
      end else if (state == ANSWER) begin
        if (tick_cnt == TW'(TICK_CYCLES - 1)) begin
          tick_cnt <= '0;
          if (secs_left != 7'd0) secs_left <= secs_left - 7'd1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
        if (state_n == SUBMIT) timed_out <= ~press;
      end

      if (state == SAMPLE && state_n == FEEDBACK) begin
        last_ok <= sample_ok;
        score   <= score + 3'(sample_ok);
      end

      if (state == ADVANCE && state_n != ADVANCE) begin
        puzzle_num <= puzzle_num + 3'd1;
        if (state_n == ANSWER) secs_left <= 7'(TIME_LIMIT_S);
      end
    end
  end

  assign busy      = (state != IDLE) && (state != DONE);
  assign game_over = (state == DONE);

endmodule
